// File: rtl/window_pkg.sv
// -----------------------------------------------------------------------------
// window_pkg
// Shared constants and helpers for the 3x3 window generator.
//   WIN_SIZE      : window edge length (3)
//   WIN_TAPS      : taps per window (9)
//   col_cnt_width : column counter / line-buffer address width for a line width
//   row_cnt_width : row counter width for a frame height
// -----------------------------------------------------------------------------
package window_pkg;

  localparam int WIN_SIZE = 3;
  localparam int WIN_TAPS = WIN_SIZE * WIN_SIZE;

  function automatic int col_cnt_width(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int row_cnt_width(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of storage, single address, read-before-write.
//   clk       : clock
//   addr_i    : column address, shared by read and write
//   we_i      : write enable
//   wr_data_i : data written at addr_i on the rising edge
//   rd_data_o : combinational read of addr_i (old contents in a write cycle)
// -----------------------------------------------------------------------------
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 8,
  localparam int AW        = col_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Combinational read sees the pre-edge contents, so a read and a write to
  // the same column in one cycle return the old value.
  assign rd_data_o = mem_q[addr_i];

  // NOTE: storage arrays get no reset; a reset would turn the RAM into a
  // flop array, and stale contents are masked by the row counter anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
// Streaming 3x3 neighbourhood generator. Raster-order pixels come in one per
// valid cycle; two line buffers hold the previous two rows. For each pixel
// that completes a full 3x3 neighbourhood the nine taps are presented with a
// one-cycle window_valid strobe (latency 1, window centred at row-1,col-1).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   pixel_in     : raster-order input pixel
//   pixel_valid  : pixel_in valid this cycle (gaps allowed)
//   sof_in       : start of frame, forces (0,0) (only with WIN_SOF_SYNC_EN)
//   in1..in9     : window taps, row-major, in1 top-left, in9 bottom-right
//   window_valid : one-cycle pulse, taps hold a complete new window
//   frame_done   : one-cycle pulse after the last pixel of a frame
//
// Configuration macro: WIN_SOF_SYNC_EN adds the sof_in resynchronisation port.
// -----------------------------------------------------------------------------
module window_3x3_gen
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
`ifdef WIN_SOF_SYNC_EN
  input  logic                  sof_in,
`endif
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] in3,
  output logic [DATA_WIDTH-1:0] in4,
  output logic [DATA_WIDTH-1:0] in5,
  output logic [DATA_WIDTH-1:0] in6,
  output logic [DATA_WIDTH-1:0] in7,
  output logic [DATA_WIDTH-1:0] in8,
  output logic [DATA_WIDTH-1:0] in9,
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int CW = col_cnt_width(IMG_WIDTH);
  localparam int RW = row_cnt_width(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [DATA_WIDTH-1:0] tap_q [WIN_TAPS];
  logic [DATA_WIDTH-1:0] tap_d [WIN_TAPS];

  logic window_valid_q, window_valid_d;
  logic frame_done_q, frame_done_d;

  // Position of the pixel being accepted this cycle (after any SOF override).
  logic          sof_hit;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic          col_last, row_last;

  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] top_feed, mid_feed;

`ifdef WIN_SOF_SYNC_EN
  assign sof_hit = pixel_valid & sof_in;
`else
  assign sof_hit = 1'b0;
`endif

  assign eff_col  = sof_hit ? '0 : col_q;
  assign eff_row  = sof_hit ? '0 : row_q;
  assign col_last = (eff_col == COL_LAST);
  assign row_last = (eff_row == ROW_LAST);

  // LB0 holds the previous row, LB1 the row before it. LB1 is refilled from
  // LB0's read port in the same cycle, so the rows ripple down together.
  line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lb0 (
    .clk       (clk),
    .addr_i    (eff_col),
    .we_i      (pixel_valid),
    .wr_data_i (pixel_in),
    .rd_data_o (lb0_rd)
  );

  line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lb1 (
    .clk       (clk),
    .addr_i    (eff_col),
    .we_i      (pixel_valid),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  // Rows that the line buffers have not yet been filled for (first rows of a
  // frame or after reset) feed zeros, so stale or uninitialised RAM never
  // reaches the taps.
  assign top_feed = (eff_row >= RW'(2)) ? lb1_rd : '0;
  assign mid_feed = (eff_row >= RW'(1)) ? lb0_rd : '0;

  // NOTE: every variable written in always_comb gets a default first, which
  // keeps the block free of inferred latches on the pixel_valid=0 path.
  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    tap_d          = tap_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;

    if (pixel_valid) begin
      col_d = col_last ? '0 : eff_col + CW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : eff_row + RW'(1);
      end else begin
        row_d = eff_row;
      end

      // Each row is a 3-deep shift register, newest column on the right.
      tap_d[0] = tap_q[1];
      tap_d[1] = tap_q[2];
      tap_d[2] = top_feed;
      tap_d[3] = tap_q[4];
      tap_d[4] = tap_q[5];
      tap_d[5] = mid_feed;
      tap_d[6] = tap_q[7];
      tap_d[7] = tap_q[8];
      tap_d[8] = pixel_in;

      // col>=2 excludes windows straddling a line wrap; row>=2 excludes the
      // first two rows of a frame.
      window_valid_d = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      frame_done_d   = col_last && row_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      tap_q          <= '{default: '0};
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      tap_q          <= tap_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign in1          = tap_q[0];
  assign in2          = tap_q[1];
  assign in3          = tap_q[2];
  assign in4          = tap_q[3];
  assign in5          = tap_q[4];
  assign in6          = tap_q[5];
  assign in7          = tap_q[6];
  assign in8          = tap_q[7];
  assign in9          = tap_q[8];
  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;

endmodule
